fir_diff_pipe: RTL and testbench
================================

FIR_DIFF_PIPE -- requirements
Module: fir_diff_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning signed two's-complement sample and gain width.
REQ-002 The block SHALL have parameter FRAC_W, default 22, meaning fractional bits of samples, gain and output.
REQ-003 The block SHALL have parameter GAIN_INIT, default 32'h000C_D014 (0.2002), meaning the gain register value after reset.
REQ-004 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Port: in_valid  input  1  in_data is a new sample this cycle.
REQ-007 Port: in_data  input  DATA_W  signed sample, Q(DATA_W-FRAC_W).FRAC_W.
REQ-008 Port: mode  input  1  sampled with in_valid; 0 = five-tap smoothed differentiator, 1 = first difference.
REQ-009 Port: gain_we  input  1  load gain_in into the gain register.
REQ-010 Port: gain_in  input  DATA_W  signed gain, same Q format as samples.
REQ-011 Port: flush  input  1  clear the sample history without resetting gain.
REQ-012 Port: out_valid  output  1  out_data and out_sat are valid.
REQ-013 Port: out_data  output  DATA_W  signed filtered result, same Q format.
REQ-014 Port: out_sat  output  1  out_data was clamped this sample.

Function
REQ-015 The history x1..x4 SHALL shift only on cycles with in_valid=1 (x1<=in_data, xk<=x(k-1)); it SHALL hold otherwise.
REQ-016 Stage 1 SHALL register s = x0+2*x1-2*x3-x4 (mode 0) or s = x0-x1 (mode 1), x0 = in_data, at width DATA_W+3, no overflow.
REQ-017 Stage 2 SHALL register p = s*gain, full width 2*DATA_W+3, using the gain register value current in that cycle.
REQ-018 Stage 3 SHALL compute r = (p + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift) and clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 out_sat SHALL be 1 exactly when the clamp changes r; it is a per-sample flag, not sticky.
REQ-020 Latency SHALL be exactly 3 cycles: a sample accepted in cycle n SHALL give out_valid=1 in cycle n+3; throughput one sample per cycle.
REQ-021 out_valid SHALL be the in_valid stream delayed 3 cycles; out_data and out_sat SHALL hold their last values while out_valid=0.
REQ-022 A gain_we in cycle n SHALL update the gain register at the end of cycle n; samples reaching stage 2 in cycle n+1 or later SHALL use the new gain.
REQ-023 flush SHALL zero x1..x4 at the end of the cycle; flush with in_valid in the same cycle SHALL compute that sample with zero history and leave x1=in_data.
REQ-024 flush SHALL NOT cancel samples already in stages 1-3.
REQ-025 A mode change SHALL apply only to the sample accepted with it; history is shared between modes.
REQ-026 Before four samples are accepted, missing history SHALL read as zero.

Reset
REQ-027 On rst=1 at a clock edge, x1..x4, all stage registers, out_data SHALL become 0, out_valid and out_sat 0, and the gain register GAIN_INIT.
REQ-028 rst SHALL override in_valid, gain_we and flush in the same cycle; samples in flight SHALL be discarded with no out_valid pulse.

Structure
REQ-029 Shared package fir_diff_pkg SHALL hold the mode encoding constants, default DATA_W/FRAC_W, and the round/saturate function.
REQ-030 One sub-module, fir_round_sat (parametrised input width, DATA_W, FRAC_W), SHALL implement REQ-018/REQ-019 combinationally; the rest stays in fir_diff_pipe.

Verification
REQ-031 Step: gain=0x0040_0000 (1.0), mode 0, in_data=0x0040_0000 every cycle from reset -> outputs 0x0040_0000, 0x00C0_0000, 0x00C0_0000, 0x0040_0000, then 0x0000_0000 steady, first at cycle 3.
REQ-032 Saturation: gain 1.0, mode 0, constant 0x7FFF_FFFF -> second output 0x7FFF_FFFF with out_sat=1; first output has out_sat=0.
REQ-033 Rounding: gain 0x0020_0000 (0.5), mode 1, in_data=1 then 0 -> outputs 1 (0.5 LSB rounded up) then 0.
REQ-034 Gaps/gain: valid every other cycle with gain_we to 2.0 mid-stream -> history advances only on valid, out_valid pattern delayed by 3, new gain applies from the sample reaching stage 2 one cycle after gain_we.
REQ-035 Flush/reset: flush after two steps -> next output equals in_data*gain; rst with 3 samples in flight -> no out_valid, gain=0x000C_D014.

Source files
------------

// File: rtl/fir_diff_pkg.sv
// Shared definitions for the differentiator pipeline: mode encoding, default
// widths and the round-half-up / saturate helper used by the output stage.
package fir_diff_pkg;

    localparam logic MODE_SMOOTH = 1'b0;
    localparam logic MODE_DIFF   = 1'b1;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_FRAC_W = 22;

    // Working width of the helper; the product of any supported instantiation fits.
    localparam int RS_MAX_W = 160;

    typedef logic signed [RS_MAX_W-1:0] rs_wide_t;

    typedef struct packed {
        logic            sat;
        logic signed [RS_MAX_W-1:0] val;
    } rs_result_t;

    function automatic rs_result_t round_sat(input rs_wide_t p, input int data_w, input int frac_w);
        rs_wide_t   one;
        rs_wide_t   r;
        rs_wide_t   hi;
        rs_wide_t   lo;
        rs_result_t res;
        one = rs_wide_t'(1);
        r   = (p + (one <<< (frac_w - 1))) >>> frac_w;
        hi  = (one <<< (data_w - 1)) - one;
        lo  = -(one <<< (data_w - 1));
        res.sat = 1'b1;
        if (r > hi) begin
            res.val = hi;
        end else if (r < lo) begin
            res.val = lo;
        end else begin
            res.sat = 1'b0;
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output stage: rounds a wide fixed-point product back to the
// sample format and clamps it, flagging when the clamp altered the value.
module fir_round_sat
    import fir_diff_pkg::*;
#(
    parameter int IN_W   = 2 * DEFAULT_DATA_W + 3,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic signed [IN_W-1:0]   p,
    output logic signed [DATA_W-1:0] r,
    output logic                     sat
);

    rs_result_t res;

    always_comb begin
        res = round_sat(rs_wide_t'(p), DATA_W, FRAC_W);
        r   = res.val[DATA_W-1:0];
        // The second term can only fire if the result does not fit DATA_W after clamping.
        sat = res.sat | (res.val != rs_wide_t'(r));
    end

endmodule

// File: rtl/fir_diff_pipe.sv
// Three-stage differentiator: tap sum, gain multiply, round/saturate.
// Five-tap smoothed derivative or first difference, selectable per sample.
module fir_diff_pipe
    import fir_diff_pkg::*;
#(
    parameter int               DATA_W    = DEFAULT_DATA_W,
    parameter int               FRAC_W    = DEFAULT_FRAC_W,
    parameter logic [DATA_W-1:0] GAIN_INIT = DATA_W'(32'h000C_D014)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic              gain_we,
    input  logic [DATA_W-1:0] gain_in,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int S_W = DATA_W + 3;
    localparam int P_W = 2 * DATA_W + 3;

    logic signed [DATA_W-1:0] hist_q [1:4];
    logic signed [DATA_W-1:0] hist_d [1:4];
    logic signed [DATA_W-1:0] hist_eff [1:4];
    logic signed [DATA_W-1:0] gain_q, gain_d;
    logic signed [S_W-1:0]    s_q, s_d;
    logic signed [P_W-1:0]    p_q, p_d;
    logic                     v1_q, v1_d;
    logic                     v2_q, v2_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [S_W-1:0]    x0, x1, x3, x4;
    logic signed [DATA_W-1:0] rs_r;
    logic                     rs_sat;

    // A flush in the same cycle as a sample makes that sample see empty history.
    generate
        for (genvar gi = 1; gi <= 4; gi++) begin : g_hist
            always_comb begin
                hist_eff[gi] = flush ? '0 : hist_q[gi];
                if (!in_valid) begin
                    hist_d[gi] = hist_eff[gi];
                end else if (gi == 1) begin
                    hist_d[gi] = $signed(in_data);
                end else begin
                    hist_d[gi] = hist_eff[gi-1];
                end
            end
        end
    endgenerate

    always_comb begin
        x0 = S_W'($signed(in_data));
        x1 = S_W'(hist_eff[1]);
        x3 = S_W'(hist_eff[3]);
        x4 = S_W'(hist_eff[4]);
        if (mode == MODE_SMOOTH) begin
            s_d = x0 + (x1 <<< 1) - (x3 <<< 1) - x4;
        end else begin
            s_d = x0 - x1;
        end
        v1_d = in_valid;

        p_d  = P_W'(s_q) * P_W'(gain_q);
        v2_d = v1_q;

        gain_d = gain_we ? $signed(gain_in) : gain_q;

        out_valid_d = v2_q;
        out_data_d  = v2_q ? rs_r : out_data_q;
        out_sat_d   = v2_q ? rs_sat : out_sat_q;
    end

    fir_round_sat #(
        .IN_W   (P_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .p   (p_q),
        .r   (rs_r),
        .sat (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= 4; k++) begin
                hist_q[k] <= '0;
            end
            gain_q      <= $signed(GAIN_INIT);
            s_q         <= '0;
            v1_q        <= 1'b0;
            p_q         <= '0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                hist_q[k] <= hist_d[k];
            end
            gain_q      <= gain_d;
            s_q         <= s_d;
            v1_q        <= v1_d;
            p_q         <= p_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_diff_pipe.sv
// Self-checking bench for fir_diff_pipe: directed vector table, hand-written
// corner sequences and a random run checked against a wide-arithmetic model.
module tb_fir_diff_pipe;

    localparam int          DATA_W    = 32;
    localparam int          FRAC_W    = 22;
    localparam logic [31:0] GAIN_INIT = 32'h000C_D014;
    localparam logic [31:0] ONE       = 32'h0040_0000;

    typedef logic signed [127:0] wide_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        mode;
    logic        gain_we;
    logic [31:0] gain_in;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    fir_diff_pipe #(
        .DATA_W    (DATA_W),
        .FRAC_W    (FRAC_W),
        .GAIN_INIT (GAIN_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .gain_we   (gain_we),
        .gain_in   (gain_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
        logic        s;
    } exp_t;

    exp_t        expq[$];
    wide_t       hist_m [1:4];
    logic [31:0] gain_m;
    logic [31:0] last_d;
    logic        last_s;
    int          cyc = 0;

    always @(posedge clk) begin
        wide_t h1, h2, h3, x0, s, prod, r;
        exp_t  e;
        cyc++;
        if (rst) begin
            for (int k = 1; k <= 4; k++) hist_m[k] = '0;
            gain_m = GAIN_INIT;
            expq.delete();
            last_d = '0;
            last_s = 1'b0;
        end else begin
            if (gain_we) gain_m = gain_in;
            if (flush) for (int k = 1; k <= 4; k++) hist_m[k] = '0;
            if (in_valid) begin
                x0 = wide_t'($signed(in_data));
                if (mode) s = x0 - hist_m[1];
                else      s = x0 + 2 * hist_m[1] - 2 * hist_m[3] - hist_m[4];
                prod = s * wide_t'($signed(gain_m));
                r = (prod + (wide_t'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
                e.due = cyc + 2;
                if (r > wide_t'(64'sh7FFF_FFFF)) begin
                    e.d = 32'h7FFF_FFFF; e.s = 1'b1;
                end else if (r < -wide_t'(64'sh8000_0000)) begin
                    e.d = 32'h8000_0000; e.s = 1'b1;
                end else begin
                    e.d = r[31:0]; e.s = 1'b0;
                end
                expq.push_back(e);
                h1 = hist_m[1]; h2 = hist_m[2]; h3 = hist_m[3];
                hist_m[1] = x0; hist_m[2] = h1; hist_m[3] = h2; hist_m[4] = h3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("model out_valid", 32'(out_valid), 32'd1);
            chk("model out_data", out_data, expq[0].d);
            chk("model out_sat", 32'(out_sat), 32'(expq[0].s));
            last_d = expq[0].d;
            last_s = expq[0].s;
            void'(expq.pop_front());
        end else begin
            chk("model idle out_valid", 32'(out_valid), 32'd0);
            chk("model hold out_data", out_data, last_d);
            chk("model hold out_sat", 32'(out_sat), 32'(last_s));
        end
    endtask

    task automatic step(input logic r, input logic v, input logic m, input logic gw,
                        input logic fl, input logic [31:0] d, input logic [31:0] g);
        rst = r; in_valid = v; mode = m; gain_we = gw; flush = fl; in_data = d; gain_in = g;
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, in_valid, mode, gain_we, flush;
        logic [31:0] in_data, gain_in;
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_s;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic m, input logic gw,
                                input logic [31:0] d, input logic [31:0] g,
                                input logic ev, input logic [31:0] ed, input logic es);
        vec_t t;
        t.rst = r; t.in_valid = v; t.mode = m; t.gain_we = gw; t.flush = 1'b0;
        t.in_data = d; t.gain_in = g; t.exp_v = ev; t.exp_d = ed; t.exp_s = es;
        return t;
    endfunction

    initial begin
        logic [31:0] d, g;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; gain_we = 1'b0; flush = 1'b0;
        in_data = '0; gain_in = '0;

        // Step response, gain 1.0, mode 0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, ONE, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 1, 32'h0040_0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 1, 32'h00C0_0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 1, 32'h00C0_0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 1, 32'h0040_0000, 0));
        tbl.push_back(mk(0, 1, 0, 0, ONE, 0, 1, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0));
        // Saturation on the second output only
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, ONE, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h7FFF_FFFF, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h7FFF_FFFF, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 1));
        // Rounding half an LSB up, gain 0.5, mode 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0020_0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].in_valid, tbl[i].mode, tbl[i].gain_we, tbl[i].flush,
                 tbl[i].in_data, tbl[i].gain_in);
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d data", i), out_data, tbl[i].exp_d);
            chk($sformatf("vec%0d sat", i), 32'(out_sat), 32'(tbl[i].exp_s));
            $display("vec %0d: v=%0b d=%h -> out_valid=%0b out_data=%h out_sat=%0b",
                     i, tbl[i].in_valid, tbl[i].in_data, out_valid, out_data, out_sat);
        end

        // Reset with three samples in flight, then default gain check
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, ONE);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, ONE, 0);
        step(1, 1, 0, 1, 1, ONE, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("reset discards in-flight", 32'(out_valid), 32'd0);
        end
        step(0, 1, 1, 0, 0, ONE, 0);
        idle();
        idle();
        chk("default gain valid", 32'(out_valid), 32'd1);
        chk("default gain data", out_data, GAIN_INIT);
        $display("reset seq: out_valid=%0b out_data=%h", out_valid, out_data);

        // Flush after two steps: next output is in_data*gain
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, ONE);
        step(0, 1, 0, 0, 0, ONE, 0);
        step(0, 1, 0, 0, 0, ONE, 0);
        step(0, 1, 0, 0, 1, 32'h0010_0000, 0);
        idle();
        idle();
        chk("flush valid", 32'(out_valid), 32'd1);
        chk("flush data", out_data, 32'h0010_0000);
        step(0, 1, 1, 0, 0, 32'h0030_0000, 0);
        idle();
        idle();
        chk("history after flush", out_data, 32'h0020_0000);
        $display("flush seq: out_data=%h", out_data);

        // Gapped stream with a gain change mid-stream
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, ONE);
        for (int i = 0; i < 14; i++) begin
            step(0, (i % 2) == 0, 0, i == 5, 0, 32'((i + 1) * 32'h0008_0000), 32'h0080_0000);
        end
        for (int i = 0; i < 3; i++) idle();
        $display("gap/gain seq: checks=%0d", checks);

        // Random run against the model
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            d = $urandom();
            if ($urandom_range(0, 3) != 0) d = {{8{d[23]}}, d[23:0]};
            g = $urandom();
            if ($urandom_range(0, 2) != 0) g = {{7{g[24]}}, g[24:0]};
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, d, g);
        end
        for (int i = 0; i < 3; i++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
